// File: rtl/error_sum_serializer.sv
// Snapshots the accumulator error sums on iStart and streams them out as a valid/ready byte frame.
// Optional trailing checksum byte when ERROR_SUM_CHECKSUM_EN is defined.
module error_sum_serializer #(
  parameter int          NUM_OUTPUTS = 8,
  parameter int          SUM_WIDTH   = 32,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic                                  iClock,
  input  logic                                  iReset,
  input  logic                                  iStart,
  input  logic [NUM_OUTPUTS-1:0][SUM_WIDTH-1:0] iErrorSums,
  input  logic                                  iByteReady,
  output logic [7:0]                            oByte,
  output logic                                  oByteValid,
  output logic                                  oBusy,
  output logic                                  oDone
);

  // state  | meaning
  // IDLE   | waiting for iStart; oDone pulses here for one cycle after a frame
  // HEADER | presenting HEADER_BYTE
  // DATA   | presenting snapshot byte byteIdx (sum 0 first, little-endian)
  // CHECK  | presenting the modulo-256 sum of all DATA bytes (checksum build only)

  localparam int NUM_BYTES = NUM_OUTPUTS * SUM_WIDTH / 8;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
`ifdef ERROR_SUM_CHECKSUM_EN
    ,
    CHECK  = 2'd3
`endif
  } state_t;

  state_t                        state;
  logic [NUM_BYTES-1:0][7:0]     snapshot;
  logic [IDX_W-1:0]              byteIdx;
  logic [IDX_W-1:0]              nextIdx;
`ifdef ERROR_SUM_CHECKSUM_EN
  logic [7:0]                    checksum;
`endif

  assign nextIdx = byteIdx + IDX_W'(1);

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state      <= IDLE;
      snapshot   <= '0;
      byteIdx    <= '0;
      oByte      <= '0;
      oByteValid <= 1'b0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
`ifdef ERROR_SUM_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            snapshot   <= iErrorSums;
            byteIdx    <= '0;
            oByte      <= HEADER_BYTE;
            oByteValid <= 1'b1;
            oBusy      <= 1'b1;
            state      <= HEADER;
`ifdef ERROR_SUM_CHECKSUM_EN
            checksum   <= '0;
`endif
          end
        end
        HEADER: begin
          if (iByteReady) begin
            byteIdx <= '0;
            oByte   <= snapshot[0];
            state   <= DATA;
          end
        end
        DATA: begin
          if (iByteReady) begin
`ifdef ERROR_SUM_CHECKSUM_EN
            checksum <= checksum + oByte;
`endif
            if (byteIdx == LAST_IDX) begin
`ifdef ERROR_SUM_CHECKSUM_EN
              // The last data byte is still on oByte, so fold it in directly.
              oByte <= checksum + oByte;
              state <= CHECK;
`else
              oByte      <= '0;
              oByteValid <= 1'b0;
              oBusy      <= 1'b0;
              oDone      <= 1'b1;
              state      <= IDLE;
`endif
            end else begin
              byteIdx <= nextIdx;
              oByte   <= snapshot[nextIdx];
            end
          end
        end
`ifdef ERROR_SUM_CHECKSUM_EN
        CHECK: begin
          if (iByteReady) begin
            oByte      <= '0;
            oByteValid <= 1'b0;
            oBusy      <= 1'b0;
            oDone      <= 1'b1;
            state      <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_error_sum_serializer.sv
// Bench for error_sum_serializer: queue-based frame model compared every cycle plus literal frame checks.
// Honours ERROR_SUM_CHECKSUM_EN for frame length and checksum byte.
module tb_error_sum_serializer;

`ifdef ERROR_SUM_CHECKSUM_EN
  localparam int FRAME = 34;
`else
  localparam int FRAME = 33;
`endif

  logic             iClock = 1'b0;
  logic             iReset = 1'b1;
  logic             iStart = 1'b0;
  logic             iByteReady = 1'b0;
  logic [7:0][31:0] iErrorSums = '0;
  logic [7:0]       oByte;
  logic             oByteValid;
  logic             oBusy;
  logic             oDone;

  error_sum_serializer dut (
    .iClock     (iClock),
    .iReset     (iReset),
    .iStart     (iStart),
    .iErrorSums (iErrorSums),
    .iByteReady (iByteReady),
    .oByte      (oByte),
    .oByteValid (oByteValid),
    .oBusy      (oBusy),
    .oDone      (oDone)
  );

  always #5 iClock = ~iClock;

  int   nCompared = 0;
  int   nMismatch = 0;
  int   doneCnt   = 0;
  bit   compareOn = 1'b0;
  logic [7:0] mQ[$];
  logic [7:0] logQ[$];
  bit   mBusy = 1'b0;
  bit   mDone = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is the header, every sum's bytes low first, then the optional checksum.
  task automatic buildFrame();
    logic [7:0] sum;
    logic [31:0] w;
    sum = 8'h00;
    mQ.push_back(8'hA5);
    for (int n = 0; n < 8; n++) begin
      w = iErrorSums[n];
      for (int b = 0; b < 4; b++) begin
        mQ.push_back(w[8*b +: 8]);
        sum = sum + w[8*b +: 8];
      end
    end
`ifdef ERROR_SUM_CHECKSUM_EN
    mQ.push_back(sum);
`endif
  endtask

  initial begin
    forever begin
      @(posedge iClock);
      if (!iReset && oByteValid && iByteReady) logQ.push_back(oByte);
      if (iReset) begin
        mQ.delete();
        mBusy = 1'b0;
        mDone = 1'b0;
      end else begin
        mDone = 1'b0;
        if (mBusy) begin
          if (iByteReady) begin
            void'(mQ.pop_front());
            if (mQ.size() == 0) begin
              mBusy = 1'b0;
              mDone = 1'b1;
            end
          end
        end else if (iStart) begin
          buildFrame();
          mBusy = 1'b1;
        end
      end
    end
  end

  always @(negedge iClock) begin
    if (compareOn) begin
      check("oByteValid", {31'd0, oByteValid}, {31'd0, mBusy});
      check("oBusy", {31'd0, oBusy}, {31'd0, mBusy});
      check("oDone", {31'd0, oDone}, {31'd0, mDone});
      check("oByte", {24'd0, oByte}, {24'd0, (mBusy ? mQ[0] : 8'h00)});
      if (oDone) doneCnt++;
    end
  end

  task automatic tick();
    @(negedge iClock);
  endtask

  task automatic startFrame();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (!oDone && n < budget) begin
      tick();
      n++;
    end
    if (!oDone) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitLog(input int size, input int budget);
    int n;
    n = 0;
    while (logQ.size() != size && n < budget) begin
      tick();
      n++;
    end
    check("log_reach", logQ.size(), size);
  endtask

  task automatic specSums();
    for (int k = 0; k < 8; k++) iErrorSums[k] = 32'h0100_0000 * k + k;
  endtask

  // Data byte i carries value i, which makes literal checks trivial.
  task automatic incSums();
    for (int k = 0; k < 8; k++) iErrorSums[k] = 32'h0302_0100 + k * 32'h0404_0404;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int doneBefore;
    tick();
    tick();
    compareOn = 1'b1;
    iReset = 1'b0;

    // Idle after reset: ready toggling does nothing.
    for (int i = 0; i < 10; i++) begin
      iByteReady = i[0];
      tick();
      check("idle_outputs", {oByteValid, oBusy, oDone, oByte}, 11'd0);
    end

    // Full frame with the documented sums and no backpressure.
    specSums();
    logQ.delete();
    iByteReady = 1'b1;
    startFrame();
    check("hdr_first", {23'd0, oByteValid, oByte}, {23'd0, 1'b1, 8'hA5});
    waitDone(60);
    check("t2_len", logQ.size(), FRAME);
    check("t2_b5", logQ[5], 8'h01);
    check("t2_b8", logQ[8], 8'h01);
    check("t2_b32", logQ[32], 8'h07);
`ifdef ERROR_SUM_CHECKSUM_EN
    check("t2_csum", logQ[33], 8'h38);
`endif
    tick();

    // Backpressure on byte 5 for three cycles.
    incSums();
    logQ.delete();
    startFrame();
    waitLog(5, 20);
    iByteReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", {23'd0, oByteValid, oByte}, {23'd0, 1'b1, 8'd4});
    end
    iByteReady = 1'b1;
    waitDone(60);
    check("t3_len", logQ.size(), FRAME);
    for (int i = 0; i < 32; i++) check("t3_data", logQ[i+1], i);
`ifdef ERROR_SUM_CHECKSUM_EN
    check("t3_csum", logQ[33], 8'hF0);
`endif
    tick();

    // Snapshot immunity and ignored iStart while busy.
    incSums();
    logQ.delete();
    doneBefore = doneCnt;
    startFrame();
    for (int k = 0; k < 8; k++) iErrorSums[k] = 32'hFFFF_FFFF;
    for (int n = 0; n < 60 && !oDone; n++) begin
      iStart = (logQ.size() == 3 || logQ.size() == 20);
      tick();
    end
    iStart = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("t4_one_frame", doneCnt - doneBefore, 1);
    check("t4_len", logQ.size(), FRAME);
    check("t4_b1", logQ[1], 8'h00);
    check("t4_b31", logQ[31], 8'd30);

    // Reset mid-frame at byte 10, then a clean new frame.
    incSums();
    logQ.delete();
    startFrame();
    waitLog(10, 30);
    iReset = 1'b1;
    doneBefore = doneCnt;
    tick();
    iReset = 1'b0;
    check("t5_abort", {oByteValid, oBusy, oDone, oByte}, 11'd0);
    for (int i = 0; i < 5; i++) tick();
    check("t5_no_done", doneCnt, doneBefore);
    logQ.delete();
    startFrame();
    check("t5_hdr", {23'd0, oByteValid, oByte}, {23'd0, 1'b1, 8'hA5});
    waitDone(60);
    check("t5_len", logQ.size(), FRAME);
    check("t5_b10", logQ[10], 8'd9);
    tick();

    // iStart coincident with oDone starts the next frame immediately.
    specSums();
    logQ.delete();
    doneBefore = doneCnt;
    startFrame();
    waitDone(60);
    for (int k = 0; k < 8; k++) iErrorSums[k] = 32'h1111_1111 * k;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    check("t6_hdr", {23'd0, oByteValid, oByte}, {23'd0, 1'b1, 8'hA5});
    waitDone(60);
    tick();
    check("t6_dones", doneCnt - doneBefore, 2);
    check("t6_len", logQ.size(), 2 * FRAME);
`ifdef ERROR_SUM_CHECKSUM_EN
    check("t6_end1", logQ[FRAME-1], 8'h38);
`else
    check("t6_end1", logQ[FRAME-1], 8'h07);
`endif
    check("t6_hdr2", logQ[FRAME], 8'hA5);
    check("t6_b5", logQ[FRAME+5], 8'h11);
    check("t6_b29", logQ[FRAME+29], 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
